// File: rtl/latch_pkg.sv
// Shared types and defaults for the arbiter that feeds the shared 4-bit latch.
package latch_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int ANCHO_DEF = 4;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CARGA   = 2'd1,
        RETENER = 2'd2
    } estado_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arbitro_latch_prioridad_rr.sv
// Rotated priority search: first set request after ptr, wrapping modulo 4.
module prioridad_rr (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       hay,
    output logic [1:0] ganador
);

    logic [1:0] idx;

    always_comb begin
        hay     = 1'b0;
        ganador = 2'd0;
        idx     = 2'd0;
        // k = 4 truncates to ptr itself, so the last granted requester is searched last
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!hay && req[idx]) begin
                hay     = 1'b1;
                ganador = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_latch.sv
// Round-robin arbiter: grants one requester, pulses the latch load, then holds HOLD cycles.
//
//   state   | meaning
//   REPOSO  | idle, sampling req for a winner
//   CARGA   | load cycle: gnt and lat_sel high for one cycle
//   RETENER | latch value held stable while the counter runs down
module arbitro_latch
    import latch_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ANCHO = ANCHO_DEF,
    parameter int HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*ANCHO-1:0] datos,
    output logic [N_REQ-1:0]       gnt,
    output logic [ANCHO-1:0]       lat_entradas,
    output logic                   lat_sel,
    output logic                   ocupado,
    output logic [1:0]             fuente
);

    localparam logic [CNT_W-1:0] CNT_CARGA = CNT_W'(HOLD - 1);

    estado_t           state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              lat_sel_q, lat_sel_d;
    logic [ANCHO-1:0]  lat_entradas_q, lat_entradas_d;
    logic              ocupado_q, ocupado_d;
    logic [1:0]        fuente_q, fuente_d;

    logic              hay;
    logic [1:0]        ganador;
    logic [ANCHO-1:0]  dato_ganador;

    prioridad_rr u_prioridad (
        .req     (req),
        .ptr     (ptr_q),
        .hay     (hay),
        .ganador (ganador)
    );

    always_comb begin
        dato_ganador = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ganador == 2'(i)) begin
                dato_ganador = datos[i*ANCHO +: ANCHO];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REPOSO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            REPOSO: begin
                if (hay) begin
                    state_d = CARGA;
                    ptr_d   = ganador;
                end
            end
            CARGA: begin
                state_d = RETENER;
                cnt_d   = CNT_CARGA;
            end
            RETENER: begin
                if (cnt_q == '0) begin
                    state_d = REPOSO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    // Output registers are loaded one edge ahead so every output is a flop.
    always_comb begin
        gnt_d          = '0;
        lat_sel_d      = 1'b0;
        lat_entradas_d = lat_entradas_q;
        ocupado_d      = 1'b0;
        fuente_d       = fuente_q;
        case (state_q)
            REPOSO: begin
                if (hay) begin
                    gnt_d          = N_REQ'(onehot4(ganador));
                    lat_sel_d      = 1'b1;
                    lat_entradas_d = dato_ganador;
                    ocupado_d      = 1'b1;
                    fuente_d       = ganador;
                end
            end
            CARGA: begin
                ocupado_d = 1'b1;
            end
            RETENER: begin
                ocupado_d = (cnt_q != '0);
            end
            default: begin
                ocupado_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q          <= 2'd3;
            cnt_q          <= '0;
            gnt_q          <= '0;
            lat_sel_q      <= 1'b0;
            lat_entradas_q <= '0;
            ocupado_q      <= 1'b0;
            fuente_q       <= 2'd0;
        end else begin
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            gnt_q          <= gnt_d;
            lat_sel_q      <= lat_sel_d;
            lat_entradas_q <= lat_entradas_d;
            ocupado_q      <= ocupado_d;
            fuente_q       <= fuente_d;
        end
    end

    assign gnt          = gnt_q;
    assign lat_sel      = lat_sel_q;
    assign lat_entradas = lat_entradas_q;
    assign ocupado      = ocupado_q;
    assign fuente       = fuente_q;

endmodule

// File: tb/tb_arbitro_latch.sv
// Scoreboard bench for arbitro_latch: a timeline model predicts grants, a monitor checks them.
module tb_arbitro_latch;

    localparam int HOLD = 2;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] dat;
        logic [1:0] src;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] datos;
    logic [3:0]  gnt;
    logic [3:0]  lat_entradas;
    logic        lat_sel;
    logic        ocupado;
    logic [1:0]  fuente;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          done = 1'b0;

    // model state, describing the DUT after the next rising edge
    int          m_ptr = 3;
    int          m_busy = 0;
    logic [3:0]  exp_lat = 4'd0;
    logic [1:0]  exp_fuente = 2'd0;
    logic        exp_ocup = 1'b0;

    arbitro_latch #(.N_REQ(4), .ANCHO(4), .HOLD(HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .datos        (datos),
        .gnt          (gnt),
        .lat_entradas (lat_entradas),
        .lat_sel      (lat_sel),
        .ocupado      (ocupado),
        .fuente       (fuente)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    // One cycle of stimulus plus the model's prediction for the coming edge.
    task automatic step(input logic rst_v, input logic [3:0] req_v, input logic [15:0] dat_v);
        exp_t e;
        int   w;
        @(negedge clk);
        rst   = rst_v;
        req   = req_v;
        datos = dat_v;
        if (rst_v) begin
            m_ptr = 3; m_busy = 0; exp_lat = 4'd0; exp_fuente = 2'd0; exp_ocup = 1'b0;
        end else if (m_busy > 0) begin
            m_busy--;
            exp_ocup = (m_busy > 0);
        end else if (req_v != 4'd0) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && req_v[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            e.gnt = 4'(1 << w);
            e.dat = dat_v[4*w +: 4];
            e.src = 2'(w);
            e.cyc = cyc + 1;
            sb.push_back(e);
            m_ptr = w; exp_lat = e.dat; exp_fuente = e.src; exp_ocup = 1'b1;
            m_busy = HOLD + 1;
        end else begin
            exp_ocup = 1'b0;
        end
        mon_en = 1'b1;
    endtask

    task automatic to_idle();
        while (m_busy != 0) step(1'b0, 4'd0, 16'($urandom));
    endtask

    initial begin : monitor
        bit   hit;
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (!mon_en) continue;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missed_grant cyc=%0d got=none expected=gnt %0h at cyc %0d",
                         cyc, sb[0].gnt, sb[0].cyc);
                void'(sb.pop_front());
            end
            hit = (sb.size() > 0 && sb[0].cyc == cyc);
            if (hit) begin
                e = sb.pop_front();
                chk("gnt", 8'(gnt), 8'(e.gnt));
                chk("lat_data", 8'(lat_entradas), 8'(e.dat));
                chk("fuente_grant", 8'(fuente), 8'(e.src));
            end else begin
                chk("gnt_idle", 8'(gnt), 8'd0);
            end
            chk("lat_sel", 8'(lat_sel), 8'(hit));
            chk("ocupado", 8'(ocupado), 8'(exp_ocup));
            chk("lat_stable", 8'(lat_entradas), 8'(exp_lat));
            chk("fuente", 8'(fuente), 8'(exp_fuente));
        end
    end

    initial begin : stimulus
        rst = 1'b1; req = 4'd0; datos = 16'd0;
        // reset held with every requester active
        step(1'b1, 4'hF, 16'h4321);
        step(1'b1, 4'hF, 16'h4321);
        // round robin with all requesters active: 0,1,2,3,0
        for (int i = 0; i < 18; i++) step(1'b0, 4'hF, 16'($urandom));
        to_idle();
        step(1'b0, 4'd0, 16'd0);
        // single request with data 9 on requester 2
        step(1'b0, 4'b0100, 16'h0900);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 16'h0900);
        // wrap-around: grant 3, then 1001 gives 0 then 3
        step(1'b0, 4'b1000, 16'hA000);
        to_idle();
        for (int i = 0; i < 10; i++) step(1'b0, 4'b1001, 16'($urandom));
        to_idle();
        // data change during hold must not reach the latch
        step(1'b0, 4'b0001, 16'h0005);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 16'h0004);
        // reset during the load cycle, pointer back to 3
        step(1'b0, 4'b0010, 16'h00B0);
        step(1'b1, 4'b0010, 16'h00B0);
        for (int i = 0; i < 6; i++) step(1'b0, 4'hF, 16'($urandom));
        // random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), 16'($urandom));
        end
        to_idle();
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 16'd0);
        done = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_grants got=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
